// File: rtl/counter_checker.sv
// counter_checker: tracks an observed counter (count or load), locks after SYNC_LEN
// consecutive correct samples and reports mismatches detected while locked.
module counter_checker #(
    parameter int WIDTH    = 8,
    parameter int SYNC_LEN = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [WIDTH-1:0] C_IN,
    input  logic             LOAD_IN,
    input  logic [WIDTH-1:0] VALUE_IN,
    input  logic             CLR_ERR,
    output logic             SYNCED,
    output logic             ERROR,
    output logic [7:0]       ERR_COUNT,
    output logic [WIDTH-1:0] LAST_BAD,
    output logic [WIDTH-1:0] LAST_EXP
);
    typedef enum logic [1:0] {UNSYNC, SYNCING, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [WIDTH-1:0] prev_c_q, prev_c_d;
    logic [WIDTH-1:0] prev_value_q, prev_value_d;
    logic             prev_load_q, prev_load_d;
    logic             prev_valid_q, prev_valid_d;
    logic             synced_q, synced_d;
    logic             error_q, error_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [WIDTH-1:0] last_bad_q, last_bad_d;
    logic [WIDTH-1:0] last_exp_q, last_exp_d;
    logic [WIDTH-1:0] expected;
    logic [3:0]       run_inc;
    logic             match;

    always_comb begin
        expected     = prev_load_q ? prev_value_q : prev_c_q + WIDTH'(1);
        match        = C_IN == expected;
        run_inc      = run_q + 4'd1;
        state_d      = state_q;
        run_d        = run_q;
        prev_c_d     = EN ? C_IN : prev_c_q;
        prev_load_d  = EN ? LOAD_IN : prev_load_q;
        prev_value_d = EN ? VALUE_IN : prev_value_q;
        prev_valid_d = EN;
        error_d      = EN && prev_valid_q && state_q == LOCKED && !match;
        if (!EN) begin
            state_d = UNSYNC;
            run_d   = 4'd0;
        end else if (state_q == UNSYNC || !prev_valid_q) begin
            state_d = SYNCING;
            run_d   = 4'd0;
        end else if (!match) begin
            state_d = SYNCING;
            run_d   = 4'd0;
        end else if (state_q == SYNCING) begin
            state_d = run_inc == 4'(SYNC_LEN) ? LOCKED : SYNCING;
            run_d   = run_inc == 4'(SYNC_LEN) ? 4'd0 : run_inc;
        end
        synced_d    = state_d == LOCKED;
        // a clear coinciding with an error leaves that error counted
        err_count_d = CLR_ERR ? {7'd0, error_d}
                    : (error_d && err_count_q != 8'hFF) ? err_count_q + 8'd1
                    : err_count_q;
        last_bad_d  = error_d ? C_IN : last_bad_q;
        last_exp_d  = error_d ? expected : last_exp_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= UNSYNC;
            run_q        <= 4'd0;
            prev_c_q     <= '0;
            prev_load_q  <= 1'b0;
            prev_value_q <= '0;
            prev_valid_q <= 1'b0;
            synced_q     <= 1'b0;
            error_q      <= 1'b0;
            err_count_q  <= 8'd0;
            last_bad_q   <= '0;
            last_exp_q   <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            prev_c_q     <= prev_c_d;
            prev_load_q  <= prev_load_d;
            prev_value_q <= prev_value_d;
            prev_valid_q <= prev_valid_d;
            synced_q     <= synced_d;
            error_q      <= error_d;
            err_count_q  <= err_count_d;
            last_bad_q   <= last_bad_d;
            last_exp_q   <= last_exp_d;
        end
    end

    assign SYNCED    = synced_q;
    assign ERROR     = error_q;
    assign ERR_COUNT = err_count_q;
    assign LAST_BAD  = last_bad_q;
    assign LAST_EXP  = last_exp_q;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed vectors push expected outputs into a queue;
// a monitor pops one entry per clock and compares it with the DUT outputs.
module tb_counter_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] c_in = 8'd0;
    logic       load_in = 1'b0;
    logic [7:0] value_in = 8'd0;
    logic       clr_err = 1'b0;
    logic       synced, error;
    logic [7:0] err_count, last_bad, last_exp;

    typedef struct {
        logic       s;
        logic       e;
        logic [7:0] n;
        logic [7:0] b;
        logic [7:0] x;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(8), .SYNC_LEN(4)) dut (
        .CLK(clk), .RESET(rst), .EN(en), .C_IN(c_in), .LOAD_IN(load_in),
        .VALUE_IN(value_in), .CLR_ERR(clr_err), .SYNCED(synced), .ERROR(error),
        .ERR_COUNT(err_count), .LAST_BAD(last_bad), .LAST_EXP(last_exp)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    task automatic st(input logic e_n, input logic [7:0] c, input logic ld, input logic [7:0] v,
                      input logic clr, input logic r, input logic s, input logic e,
                      input logic [7:0] n, input logic [7:0] b, input logic [7:0] x);
        @(negedge clk);
        en = e_n; c_in = c; load_in = ld; value_in = v; clr_err = clr; rst = r;
        q.push_back('{s: s, e: e, n: n, b: b, x: x});
    endtask

    initial begin
        exp_t t;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                t = q.pop_front();
                chk("synced", {7'd0, synced}, {7'd0, t.s});
                chk("error", {7'd0, error}, {7'd0, t.e});
                chk("err_count", err_count, t.n);
                chk("last_bad", last_bad, t.b);
                chk("last_exp", last_exp, t.x);
            end
        end
    end

    initial begin
        logic [7:0] c, b, x, n;
        st(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        st(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st(1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(1, 5, 1, 253, 0, 0, 1, 0, 0, 0, 0);
        st(1, 253, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(1, 254, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(1, 255, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(1, 1, 1, 20, 0, 0, 1, 0, 0, 0, 0);
        st(1, 20, 1, 42, 0, 0, 1, 0, 0, 0, 0);
        st(1, 42, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(1, 43, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(1, 44, 1, 20, 0, 0, 1, 0, 0, 0, 0);
        st(1, 20, 1, 42, 0, 0, 1, 0, 0, 0, 0);
        st(1, 21, 0, 0, 0, 0, 0, 1, 1, 21, 42);
        st(1, 22, 0, 0, 0, 0, 0, 0, 1, 21, 42);
        st(1, 23, 0, 0, 0, 0, 0, 0, 1, 21, 42);
        st(1, 24, 0, 0, 0, 0, 0, 0, 1, 21, 42);
        st(1, 25, 0, 0, 0, 0, 1, 0, 1, 21, 42);
        st(0, 99, 0, 0, 0, 0, 0, 0, 1, 21, 42);
        st(1, 26, 0, 0, 0, 0, 0, 0, 1, 21, 42);
        st(1, 27, 0, 0, 0, 0, 0, 0, 1, 21, 42);
        st(1, 28, 0, 0, 0, 0, 0, 0, 1, 21, 42);
        st(1, 29, 0, 0, 0, 0, 0, 0, 1, 21, 42);
        st(1, 30, 0, 0, 0, 0, 1, 0, 1, 21, 42);
        st(1, 31, 0, 0, 1, 0, 1, 0, 0, 21, 42);
        c = 8'd31;
        n = 8'd0;
        for (int i = 0; i < 256; i++) begin
            n = (n == 8'd255) ? n : n + 8'd1;
            b = c + 8'd5;
            x = c + 8'd1;
            st(1, b, 0, 0, 0, 0, 0, 1, n, b, x);
            c = b;
            for (int k = 1; k <= 4; k++) st(1, 8'(c + 8'(k)), 0, 0, 0, 0, k == 4, 0, n, b, x);
            c = c + 8'd4;
        end
        b = c + 8'd5;
        x = c + 8'd1;
        st(1, b, 0, 0, 1, 0, 0, 1, 1, b, x);
        c = b;
        for (int k = 1; k <= 4; k++) st(1, 8'(c + 8'(k)), 0, 0, 0, 0, k == 4, 0, 1, b, x);
        c = c + 8'd4;
        b = c + 8'd5;
        x = c + 8'd1;
        st(1, b, 0, 0, 0, 0, 0, 1, 2, b, x);
        st(1, 99, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        st(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st(1, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st(1, 51, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st(1, 52, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st(1, 53, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st(1, 54, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(1, 55, 1, 56, 0, 0, 1, 0, 0, 0, 0);
        st(1, 56, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
